// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the MAC datapath: operand classes,
// exponent constants, canonical NaN and exception-flag bit positions.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam int FLAGS_W        = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Quiet NaN {0, all-ones exponent, 1, 0...}; callers keep the low W bits.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = 64'(fp_exp_max(exp_w)) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised mantissa with guard/sticky bits.
// A carry out means the mantissa wrapped to zero and the exponent must step up.
module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0] mant,
  input  logic             guard,
  input  logic             sticky,
  output logic [MAN_W-1:0] mant_rnd,
  output logic             carry,
  output logic             inexact
);

  logic inc;

  assign inc                 = guard & (sticky | mant[0]);
  assign {carry, mant_rnd}   = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
  assign inexact             = guard | sticky;

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (unpack, normalise/round, pack) with
// DAZ/FTZ, RNE rounding, special-value handling and exception flags.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [FLAGS_W-1:0]     out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS     = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(fp_exp_max(EXP_W));
  localparam logic signed [XW-1:0] EXP_ONE  = 1;
  localparam logic signed [XW-1:0] EXP_ZERO = 0;
  localparam logic [63:0]          QNAN64   = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN     = QNAN64[W-1:0];

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] m);
    if (e == '0) return FP_ZERO;
    if (e == '1) return (m == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  // Handshake: an operand transfers when in_valid & in_ready. The whole pipe
  // advances (bubbles included) whenever the output slot is empty or being
  // consumed; otherwise every stage holds and out_res/out_flags stay stable.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  assign {sa, ea, ma} = in_a;
  assign {sb, eb, mb} = in_b;

  logic                    s1_valid;
  logic                    s1_sign;
  fp_class_e               s1_cls_a, s1_cls_b;
  logic signed [XW-1:0]    s1_exp;
  logic [PW-1:0]           s1_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls_a <= FP_ZERO;
      s1_cls_b <= FP_ZERO;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= sa ^ sb;
      s1_cls_a <= classify(ea, ma);
      s1_cls_b <= classify(eb, mb);
      s1_exp   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      s1_prod  <= PW'({1'b1, ma}) * PW'({1'b1, mb});
    end
  end

  // Normalise so the leading one sits at PW-1; the hidden bit is then dropped.
  logic [PW-1:0]           norm;
  logic signed [XW-1:0]    exp_n;
  logic [MAN_W-1:0]        mant_n, mant_r;
  logic                    guard, sticky, carry, inexact;

  assign norm   = s1_prod[PW-1] ? s1_prod : (s1_prod << 1);
  assign exp_n  = s1_prod[PW-1] ? s1_exp + EXP_ONE : s1_exp;
  assign mant_n = norm[PW-2 -: MAN_W];
  assign guard  = norm[PW-2-MAN_W];
  assign sticky = |norm[PW-3-MAN_W:0];

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .mant     (mant_n),
    .guard    (guard),
    .sticky   (sticky),
    .mant_rnd (mant_r),
    .carry    (carry),
    .inexact  (inexact)
  );

  logic                    s2_valid;
  logic                    s2_sign;
  fp_class_e               s2_cls_a, s2_cls_b;
  logic signed [XW-1:0]    s2_exp;
  logic [MAN_W-1:0]        s2_mant;
  logic                    s2_inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_cls_a   <= FP_ZERO;
      s2_cls_b   <= FP_ZERO;
      s2_exp     <= '0;
      s2_mant    <= '0;
      s2_inexact <= 1'b0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_cls_a   <= s1_cls_a;
      s2_cls_b   <= s1_cls_b;
      s2_exp     <= carry ? exp_n + EXP_ONE : exp_n;
      s2_mant    <= mant_r;
      s2_inexact <= inexact;
    end
  end

  logic [W-1:0]       res_n;
  logic [FLAGS_W-1:0] flags_n;
  logic               any_nan, any_inf, any_zero;

  assign any_nan  = (s2_cls_a == FP_NAN)  || (s2_cls_b == FP_NAN);
  assign any_inf  = (s2_cls_a == FP_INF)  || (s2_cls_b == FP_INF);
  assign any_zero = (s2_cls_a == FP_ZERO) || (s2_cls_b == FP_ZERO);

  always_comb begin
    res_n   = '0;
    flags_n = '0;
    if (any_nan) begin
      res_n = QNAN;
    end else if (any_inf && any_zero) begin
      res_n                 = QNAN;
      flags_n[FLAG_INVALID] = 1'b1;
    end else if (any_inf) begin
      res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      res_n = {s2_sign, {(W-1){1'b0}}};
    end else if (s2_exp >= EXP_MAX) begin
      res_n                  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n[FLAG_OVERFLOW] = 1'b1;
      flags_n[FLAG_INEXACT]  = 1'b1;
    end else if (s2_exp <= EXP_ZERO) begin
      res_n                   = {s2_sign, {(W-1){1'b0}}};
      flags_n[FLAG_UNDERFLOW] = 1'b1;
      flags_n[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_n                 = {s2_sign, s2_exp[EXP_W-1:0], s2_mant};
      flags_n[FLAG_INEXACT] = s2_inexact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_res   <= res_n;
      out_flags <= flags_n;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: single precision plus a half-precision
// instance, directed vectors, backpressure and mid-flight reset.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  out_flags;

  logic        h_in_valid, h_in_ready, h_out_valid;
  logic [15:0] h_in_a, h_in_b, h_out_res;
  logic [3:0]  h_out_flags;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_a(h_in_a), .in_b(h_in_b),
    .out_valid(h_out_valid), .out_ready(1'b1),
    .out_res(h_out_res), .out_flags(h_out_flags)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [35:0] exp_q[$];
  logic [19:0] h_q[$];
  logic [35:0] mon_e;
  logic [19:0] mon_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Single-precision monitor: compare head on every presented output.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h/%b want no output", out_res, out_flags);
      end else begin
        mon_e = exp_q[0];
        check("res", out_res, mon_e[35:4]);
        check("flags", 32'(out_flags), 32'(mon_e[3:0]));
        if (out_ready) void'(exp_q.pop_front());
        else check("stall_in_ready", 32'(in_ready), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && h_out_valid) begin
      if (h_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_half_output: got %h/%b want no output", h_out_res, h_out_flags);
      end else begin
        mon_h = h_q.pop_front();
        check("half_res", 32'(h_out_res), 32'(mon_h[19:4]));
        check("half_flags", 32'(h_out_flags), 32'(mon_h[3:0]));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [3:0] fl);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 want 1 for %h*%h", a, b);
    end else begin
      exp_q.push_back({res, fl});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_h(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic [3:0] fl);
    int budget;
    budget     = 0;
    h_in_valid = 1'b1;
    h_in_a     = a;
    h_in_b     = b;
    @(negedge clk);
    while (!h_in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!h_in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_h_timeout: got in_ready 0 want 1 for %h*%h", a, b);
    end else begin
      h_q.push_back({res, fl});
    end
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || h_q.size() != 0) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_single", 32'(exp_q.size()), 32'd0);
    check("drain_half", 32'(h_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Called right after send() returns on an empty pipe.
  task automatic measure_latency(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check(name, 32'(n), 32'd3);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b1;
    h_in_valid = 1'b0;
    h_in_a     = '0;
    h_in_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_half_out_valid", 32'(h_out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    measure_latency("latency_first");
    drain();

    // Back-to-back directed vectors.
    send(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    send(32'h3F800003, 32'h3F800003, 32'h3F800006, 4'b0001);
    send(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001);
    send(32'h3FA00000, 32'h3F800002, 32'h3FA00002, 4'b0001);
    send(32'h3F918E00, 32'h3FE12000, 32'h40000000, 4'b0001);
    send(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    send(32'hFF000000, 32'h40000000, 32'hFF800000, 4'b0101);
    send(32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 4'b0000);
    send(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
    send(32'h80800000, 32'h00800000, 32'h80000000, 4'b0011);
    send(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    send(32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000);
    send(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    send(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
    send(32'h7FC00000, 32'h00000000, 32'h7FC00000, 4'b0000);
    send(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
    send(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
    send(32'h80000000, 32'h40400000, 32'h80000000, 4'b0000);
    drain();

    // Half precision.
    send_h(16'h3D55, 16'h3E00, 16'h4000, 4'b0001);
    send_h(16'h3E00, 16'h4000, 16'h4200, 4'b0000);
    send_h(16'h7800, 16'h4000, 16'h7C00, 4'b0101);
    send_h(16'h0400, 16'h0400, 16'h0000, 4'b0011);
    send_h(16'h7C01, 16'h3C00, 16'h7E00, 4'b0000);
    send_h(16'hFC00, 16'h0000, 16'h7E00, 4'b1000);
    drain();

    // Backpressure: six operands while the consumer stalls for five cycles.
    fork
      begin
        logic [31:0] b;
        for (int i = 0; i < 6; i++) begin
          b = 32'h40100000 + (32'(i) << 20);
          send(32'h3F800000, b, b, 4'b0000);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operations in every stage.
    send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    send(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    send(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_res", out_res, 32'd0);
    check("async_rst_out_flags", 32'(out_flags), 32'd0);
    @(posedge clk);
    #1;
    check("held_rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    send(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
    measure_latency("latency_after_reset");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
